// File: rtl/stream_cipher_pkg.sv
// Shared constants and LFSR step helper for the stream-cipher buffer.
package stream_cipher_pkg;

    localparam int unsigned LFSR_MAX_W = 32;
    localparam logic [15:0] TAPS_16      = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Galois, right-shifting; callers zero-extend narrower LFSRs and truncate the result.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return (state >> 1) ^ (state[0] ? taps : {LFSR_MAX_W{1'b0}});
    endfunction

endpackage

// File: rtl/stream_cipher_lfsr.sv
// Keystream generator: stored key, seed resolution (zero seed -> DEFAULT_SEED) and LFSR stepping.
module stream_cipher_lfsr
    import stream_cipher_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LFSR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load_i,
    input  logic [LFSR_W-1:0] key_data_i,
    input  logic              clear_i,
    input  logic              step_i,
    output logic [DATA_W-1:0] ks_o
);

    localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(TAPS_16);
    localparam logic [LFSR_W-1:0] SEED_DFLT = LFSR_W'(DEFAULT_SEED);

    logic [LFSR_W-1:0] key_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] seed_s;
    logic [LFSR_W-1:0] lfsr_next_s;

    assign seed_s      = (key_data_i == {LFSR_W{1'b0}}) ? SEED_DFLT : key_data_i;
    assign lfsr_next_s = LFSR_W'(lfsr_step(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(TAPS)));
    assign ks_o        = lfsr_q[DATA_W-1:0];

    // Key register and LFSR state: load beats clear beats step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= SEED_DFLT;
            lfsr_q <= SEED_DFLT;
        end else if (key_load_i) begin
            key_q  <= seed_s;
            lfsr_q <= seed_s;
        end else if (clear_i) begin
            lfsr_q <= key_q;
        end else if (step_i) begin
            lfsr_q <= lfsr_next_s;
        end
    end

endmodule

// File: rtl/stream_cipher_buf.sv
// Stream-cipher circular buffer: chains LFSR keystream into ciphertext, stores {ct, mask} per entry.
// Define STREAM_CIPHER_OVERWRITE_EN to let accepts overwrite the oldest entry when full.
module stream_cipher_buf
    import stream_cipher_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned LFSR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     key_load,
    input  logic [LFSR_W-1:0]        key_data,
    input  logic                     clear,
    input  logic                     view_ct,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
`ifdef STREAM_CIPHER_OVERWRITE_EN
    localparam logic OVW_EN = 1'b1;
`else
    localparam logic OVW_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] ct;
        logic [DATA_W-1:0] mask;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic [DATA_W-1:0] prev_ct_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    logic              full_s;
    logic              accept_s;
    logic [DATA_W-1:0] ks_s;
    logic [DATA_W-1:0] mask_s;
    logic [DATA_W-1:0] ct_s;
    logic [AW-1:0]     rd_e_s;
    entry_t            rd_entry_s;

    assign full_s   = (count_q == DEPTH_C);
    assign in_ready = !key_load && !clear && (!full_s || OVW_EN);
    assign accept_s = in_valid && in_ready;
    assign mask_s   = ks_s ^ prev_ct_q;
    assign ct_s     = in_data ^ mask_s;

    assign count   = count_q;
    assign full    = full_s;
    assign empty   = (count_q == {(AW+1){1'b0}});
    assign rd_data = rd_data_q;

    stream_cipher_lfsr #(
        .DATA_W (DATA_W),
        .LFSR_W (LFSR_W)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load_i (key_load),
        .key_data_i (key_data),
        .clear_i    (clear),
        .step_i     (accept_s),
        .ks_o       (ks_s)
    );

    // Pointers, occupancy and chaining state; a full accept (overwrite) drops the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {(AW+1){1'b0}};
            prev_ct_q <= {DATA_W{1'b0}};
        end else if (key_load || clear) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {(AW+1){1'b0}};
            prev_ct_q <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            wr_ptr_q  <= wr_ptr_q + AW'(1);
            prev_ct_q <= ct_s;
            if (full_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end else begin
                count_q  <= count_q + (AW+1)'(1);
            end
        end
    end

    // Entry storage; stale contents are hidden by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wr_ptr_q] <= '{ct: ct_s, mask: mask_s};
        end
    end

    assign rd_e_s     = rd_ptr_q + rd_idx;
    assign rd_entry_s = mem_q[rd_e_s];

    // Read mux: out-of-range indices return zero, plaintext is recovered with the stored mask.
    always_comb begin
        rd_data_d = {DATA_W{1'b0}};
        if ({1'b0, rd_idx} >= count_q) begin
            rd_data_d = {DATA_W{1'b0}};
        end else if (view_ct) begin
            rd_data_d = rd_entry_s.ct;
        end else begin
            rd_data_d = rd_entry_s.ct ^ rd_entry_s.mask;
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= {DATA_W{1'b0}};
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_stream_cipher_buf.sv
// Directed self-checking bench for stream_cipher_buf (DATA_W=8, DEPTH=8, LFSR_W=16).
module tb_stream_cipher_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        key_load;
    logic [15:0] key_data;
    logic        clear;
    logic        view_ct;
    logic [2:0]  rd_idx;
    logic [7:0]  rd_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int n_checks = 0;
    int n_errors = 0;

    stream_cipher_buf #(.DATA_W(8), .DEPTH(8), .LFSR_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .key_load (key_load),
        .key_data (key_data),
        .clear    (clear),
        .view_ct  (view_ct),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_key_load(input logic [15:0] k);
        key_load = 1'b1;
        key_data = k;
        tick();
        key_load = 1'b0;
    endtask

    task automatic do_read(input logic v, input logic [2:0] idx);
        view_ct = v;
        rd_idx  = idx;
        tick();
    endtask

    task automatic test_reset();
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_flags: empty=%b full=%b count=%0d in_ready=%b, expected 1 0 0 1",
                     empty, full, count, in_ready);
        end
        for (int i = 0; i < 8; i += 5) begin
            do_read(1'b1, 3'(i));
            n_checks++;
            if (rd_data !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_rd idx%0d: got %h expected 00", i, rd_data);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_ct [2];
        logic [7:0] exp_pt [2];
        exp_ct[0] = 8'hA0; exp_ct[1] = 8'h92;
        exp_pt[0] = 8'h41; exp_pt[1] = 8'h42;
        do_key_load(16'hACE1);
        push(8'h41);
        push(8'h42);
        n_checks++;
        if (count !== 4'd2 || empty !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_count: count=%0d empty=%b expected 2 0", count, empty);
        end
        for (int i = 0; i < 2; i++) begin
            do_read(1'b1, 3'(i));
            n_checks++;
            if (rd_data !== exp_ct[i]) begin
                n_errors++;
                $display("FAIL basic_ct idx%0d: got %h expected %h", i, rd_data, exp_ct[i]);
            end
            do_read(1'b0, 3'(i));
            n_checks++;
            if (rd_data !== exp_pt[i]) begin
                n_errors++;
                $display("FAIL basic_pt idx%0d: got %h expected %h", i, rd_data, exp_pt[i]);
            end
        end
        do_read(1'b1, 3'd2);
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_errors++;
            $display("FAIL basic_out_of_range: got %h expected 00", rd_data);
        end
    endtask

    task automatic test_fill();
        logic [7:0] exp0;
        logic [7:0] exp7;
        do_key_load(16'hACE1);
        for (int i = 1; i <= 8; i++) begin
            push(8'(i));
        end
        n_checks++;
        if (full !== 1'b1 || count !== 4'd8) begin
            n_errors++;
            $display("FAIL fill_full: full=%b count=%0d expected 1 8", full, count);
        end
        in_valid = 1'b1;
        in_data  = 8'h09;
        #1;
`ifdef STREAM_CIPHER_OVERWRITE_EN
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_ready: got %b expected 1", in_ready);
        end
        exp0 = 8'h02;
        exp7 = 8'h09;
`else
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_ready: got %b expected 0", in_ready);
        end
        exp0 = 8'h01;
        exp7 = 8'h08;
`endif
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_after9: count=%0d full=%b expected 8 1", count, full);
        end
        do_read(1'b0, 3'd0);
        n_checks++;
        if (rd_data !== exp0) begin
            n_errors++;
            $display("FAIL fill_idx0: got %h expected %h", rd_data, exp0);
        end
        do_read(1'b0, 3'd7);
        n_checks++;
        if (rd_data !== exp7) begin
            n_errors++;
            $display("FAIL fill_idx7: got %h expected %h", rd_data, exp7);
        end
    endtask

    task automatic test_key_load_collision();
        key_load = 1'b1;
        key_data = 16'h1234;
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL collide_ready: got %b expected 0", in_ready);
        end
        tick();
        key_load = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL collide_count: count=%0d empty=%b expected 0 1", count, empty);
        end
        // seed 0x1234 -> ks 0x34; 0x41 ^ 0x34 = 0x75
        push(8'h41);
        do_read(1'b1, 3'd0);
        n_checks++;
        if (rd_data !== 8'h75) begin
            n_errors++;
            $display("FAIL collide_newseed_ct: got %h expected 75", rd_data);
        end
    endtask

    task automatic test_zero_seed();
        do_key_load(16'h0000);
        push(8'h41);
        do_read(1'b1, 3'd0);
        n_checks++;
        if (rd_data !== 8'hA0) begin
            n_errors++;
            $display("FAIL zero_seed_ct: got %h expected a0", rd_data);
        end
    endtask

    task automatic test_clear();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        push(8'h41);
        n_checks++;
        if (count !== 4'd1) begin
            n_errors++;
            $display("FAIL clear_count: got %0d expected 1", count);
        end
        do_read(1'b1, 3'd0);
        n_checks++;
        if (rd_data !== 8'hA0) begin
            n_errors++;
            $display("FAIL clear_ct: got %h expected a0", rd_data);
        end
    endtask

    task automatic test_back_to_back();
        // read idx1 in the same cycle as the push of 0x42: pre-write count is 1, so it reads 0
        view_ct = 1'b0;
        rd_idx  = 3'd1;
        push(8'h42);
        n_checks++;
        if (rd_data !== 8'h00 || count !== 4'd2) begin
            n_errors++;
            $display("FAIL b2b_prewrite: rd=%h count=%0d expected 00 2", rd_data, count);
        end
        do_read(1'b0, 3'd1);
        n_checks++;
        if (rd_data !== 8'h42) begin
            n_errors++;
            $display("FAIL b2b_postwrite: got %h expected 42", rd_data);
        end
        do_read(1'b1, 3'd1);
        n_checks++;
        if (rd_data !== 8'h92) begin
            n_errors++;
            $display("FAIL b2b_ct: got %h expected 92", rd_data);
        end
    endtask

    task automatic test_async_reset();
        do_read(1'b1, 3'd0);
        in_valid = 1'b1;
        in_data  = 8'h33;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd_data !== 8'h00 || count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL async_reset: rd=%h count=%0d empty=%b full=%b ready=%b expected 00 0 1 0 1",
                     rd_data, count, empty, full, in_ready);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        push(8'h41);
        do_read(1'b1, 3'd0);
        n_checks++;
        if (rd_data !== 8'hA0) begin
            n_errors++;
            $display("FAIL post_reset_ct: got %h expected a0", rd_data);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        key_load = 1'b0;
        key_data = 16'h0000;
        clear    = 1'b0;
        view_ct  = 1'b0;
        rd_idx   = 3'd0;
        #12;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_fill();
        test_key_load_collision();
        test_zero_seed();
        test_clear();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
